// File: rtl/l1_icache_sa_if.sv
// Fetch-side and memory-side signal bundle for the L1 instruction cache.
// The cache attaches through the slave modport; the fetch stage / memory
// model (or a testbench standing in for both) attaches through master.
interface l1_icache_sa_if;
    logic        cpu_req_valid;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_data;
    logic        inv_all;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic [7:0]  mem_req_len;
    logic        mem_req_ready;
    logic        mem_data_valid;
    logic [31:0] mem_data;

    modport slave (
        input  cpu_req_valid, cpu_req_addr, inv_all,
        input  mem_req_ready, mem_data_valid, mem_data,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_len
    );

    modport master (
        output cpu_req_valid, cpu_req_addr, inv_all,
        output mem_req_ready, mem_data_valid, mem_data,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_len
    );
endinterface

// File: rtl/l1_icache_sa.sv
// Blocking, read-only, 1- or 2-way set-associative L1 instruction cache.
// Tag compare is done in the accept cycle against the incoming address and
// the result is registered, so hit responses and the miss decision both
// appear in the cycle after acceptance. Refill beats pass through one
// capture register before being written, which places the replayed response
// two cycles after the last beat. Data arrays are deliberately not reset.
module l1_icache_sa #(
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input logic          clk,
    input logic          rst,
    l1_icache_sa_if.slave bus
);

    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = 30 - OFF - IDX;
    localparam int LASTI = LINE_WORDS - 1;
    localparam logic [OFF-1:0] LAST_W   = LASTI[OFF-1:0];
    localparam logic [OFF-1:0] ONE_W    = {{(OFF-1){1'b0}}, 1'b1};
    localparam logic [OFF:0]   ONE_C    = {{OFF{1'b0}}, 1'b1};
    localparam logic [7:0]     LEN_C    = LASTI[7:0];

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, REPLAY} state_t;

    state_t state_r;
    state_t state_nx_s;

    // Storage: per-way valid/tag/data, one LRU (victim) bit per set.
    logic [SETS-1:0] valid_r [WAYS];
    logic [TAG-1:0]  tag_r   [WAYS][SETS];
    logic [31:0]     data_r  [WAYS][SETS*LINE_WORDS];
    logic [SETS-1:0] lru_r;

    // Held request and miss bookkeeping.
    logic [31:2]     req_addr_r;
    logic            miss_r;
    logic            victim_r;
    logic [31:0]     mem_addr_r;
    logic            inv_pend_r;

    // Refill capture and write pipeline.
    logic [OFF:0]    cap_cnt_r;
    logic [OFF-1:0]  wr_cnt_r;
    logic            beat_v_r;
    logic [31:0]     beat_d_r;

    // Registered response.
    logic            resp_valid_r;
    logic [31:0]     resp_data_r;

    // Incoming address split.
    logic [OFF-1:0]  in_off_s;
    logic [IDX-1:0]  in_idx_s;
    logic [TAG-1:0]  in_tag_s;

    // Held address split.
    logic [OFF-1:0]  req_off_s;
    logic [IDX-1:0]  req_idx_s;
    logic [TAG-1:0]  req_tag_s;

    logic            ready_s;
    logic            acc_s;
    logic            hit_s;
    logic            hit_way_s;
    logic [31:0]     hit_word_s;
    logic            victim_s;
    logic            cap_s;
    logic            we_s;
    logic            done_s;
    logic            clr_s;
    logic [31:0]     rep_word_s;
    logic            unused_s;

    assign in_off_s  = bus.cpu_req_addr[OFF+1:2];
    assign in_idx_s  = bus.cpu_req_addr[OFF+IDX+1:OFF+2];
    assign in_tag_s  = bus.cpu_req_addr[31:OFF+IDX+2];
    assign req_off_s = req_addr_r[OFF+1:2];
    assign req_idx_s = req_addr_r[OFF+IDX+1:OFF+2];
    assign req_tag_s = req_addr_r[31:OFF+IDX+2];
    assign unused_s  = ^bus.cpu_req_addr[1:0];

    // New requests are taken only in IDLE (outside a pending miss lookup) or
    // REPLAY, and never in an invalidate pulse cycle or during reset.
    assign ready_s = rst && !bus.inv_all &&
                     (((state_r == IDLE) && !miss_r) || (state_r == REPLAY));
    assign acc_s   = bus.cpu_req_valid && ready_s;

    // Beats are captured only inside REFILL and only until a full line is in.
    assign cap_s   = (state_r == REFILL) && bus.mem_data_valid && !cap_cnt_r[OFF];
    assign we_s    = beat_v_r && (state_r == REFILL);
    assign done_s  = we_s && (wr_cnt_r == LAST_W);

    // Immediate invalidate in IDLE/REPLAY, deferred one applied at end of REPLAY.
    assign clr_s   = (bus.inv_all && ((state_r == IDLE) || (state_r == REPLAY))) ||
                     ((state_r == REPLAY) && inv_pend_r);

    // The final beat is still in the capture register when the line completes.
    assign rep_word_s = (req_off_s == LAST_W) ? beat_d_r
                                              : data_r[victim_r][{req_idx_s, req_off_s}];

    assign bus.cpu_req_ready  = ready_s;
    assign bus.cpu_resp_valid = resp_valid_r;
    assign bus.cpu_resp_data  = resp_data_r;
    assign bus.mem_req_valid  = (state_r == MISS_REQ);
    assign bus.mem_req_addr   = mem_addr_r;
    assign bus.mem_req_len    = LEN_C;

    // Tag compare across all ways for the incoming request address.
    always_comb begin
        hit_s      = 1'b0;
        hit_way_s  = 1'b0;
        hit_word_s = 32'h0000_0000;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_r[w][in_idx_s] && (tag_r[w][in_idx_s] == in_tag_s)) begin
                hit_s      = 1'b1;
                hit_way_s  = 1'(w);
                hit_word_s = data_r[w][{in_idx_s, in_off_s}];
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // Victim choice: first invalid way (way 0 first), otherwise the LRU way.
    always_comb begin
        victim_s = 1'b0;
        if (!valid_r[0][req_idx_s]) begin
            victim_s = 1'b0;
        end else if ((WAYS == 2) && !valid_r[WAYS-1][req_idx_s]) begin
            victim_s = 1'b1;
        end else if (WAYS == 2) begin
            victim_s = lru_r[req_idx_s];
        end else begin
            victim_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_r) begin
                    state_nx_s = MISS_REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MISS_REQ: begin
                if (bus.mem_req_ready) begin
                    state_nx_s = REFILL;
                end else begin
                    state_nx_s = MISS_REQ;
                end
            end
            REFILL: begin
                if (done_s) begin
                    state_nx_s = REPLAY;
                end else begin
                    state_nx_s = REFILL;
                end
            end
            REPLAY:  state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Accepted request address and one-cycle miss flag for the lookup cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_addr_r <= 30'd0;
            miss_r     <= 1'b0;
        end else begin
            if (acc_s) begin
                req_addr_r <= bus.cpu_req_addr[31:2];
            end
            miss_r <= acc_s && !hit_s;
        end
    end

    // Burst address and victim way, latched as the miss is committed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_addr_r <= 32'h0000_0000;
            victim_r   <= 1'b0;
        end else if ((state_r == IDLE) && miss_r) begin
            mem_addr_r <= {req_addr_r[31:OFF+2], {(OFF+2){1'b0}}};
            victim_r   <= victim_s;
        end
    end

    // Invalidates arriving while memory is busy are remembered until REPLAY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inv_pend_r <= 1'b0;
        end else if (state_r == REPLAY) begin
            inv_pend_r <= 1'b0;
        end else if (bus.inv_all && ((state_r == MISS_REQ) || (state_r == REFILL))) begin
            inv_pend_r <= 1'b1;
        end
    end

    // Beat capture register and the capture/write counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_cnt_r <= '0;
            wr_cnt_r  <= '0;
            beat_v_r  <= 1'b0;
            beat_d_r  <= 32'h0000_0000;
        end else begin
            beat_v_r <= cap_s;
            if (cap_s) begin
                beat_d_r <= bus.mem_data;
            end
            if (state_r == MISS_REQ) begin
                cap_cnt_r <= '0;
                wr_cnt_r  <= '0;
            end else begin
                if (cap_s) begin
                    cap_cnt_r <= cap_cnt_r + ONE_C;
                end
                if (we_s) begin
                    wr_cnt_r <= wr_cnt_r + ONE_W;
                end
            end
        end
    end

    // Response register: hit word in the lookup cycle or the replayed word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
        end else if (done_s) begin
            resp_valid_r <= 1'b1;
            resp_data_r  <= rep_word_s;
        end else if (acc_s && hit_s) begin
            resp_valid_r <= 1'b1;
            resp_data_r  <= hit_word_s;
        end else begin
            resp_valid_r <= 1'b0;
        end
    end

    // Valid and LRU state: cleared by reset/invalidate, updated on fill and hit.
    always_ff @(posedge clk) begin
        if (!rst || clr_s) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_r[w] <= '0;
            end
            lru_r <= '0;
        end else begin
            if (done_s) begin
                valid_r[victim_r][req_idx_s] <= 1'b1;
                lru_r[req_idx_s]             <= ~victim_r;
            end
            if (acc_s && hit_s) begin
                lru_r[in_idx_s] <= ~hit_way_s;
            end
        end
    end

    // Data and tag arrays: refill writes only, no reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            data_r[victim_r][{req_idx_s, wr_cnt_r}] <= beat_d_r;
        end
        if (done_s) begin
            tag_r[victim_r][req_idx_s] <= req_tag_s;
        end
    end

endmodule
